// File: rtl/wb_io_pkg.sv
// ============================================================================
// Module      : wb_io_pkg
// Description : Shared types and Wishbone constants for the I/O arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } wb_arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/wb_io_arbiter_if.sv
// ============================================================================
// Module      : wb_io_arbiter_if
// Description : Wishbone master-side and slave-side bundle of the I/O arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_io_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS*32-1:0] wbm_adr_i;
    logic [NUM_MASTERS*32-1:0] wbm_dat_i;
    logic [NUM_MASTERS*4-1:0]  wbm_sel_i;
    logic [NUM_MASTERS-1:0]    wbm_we_i;
    logic [NUM_MASTERS-1:0]    wbm_cyc_i;
    logic [NUM_MASTERS-1:0]    wbm_stb_i;
    logic [NUM_MASTERS*3-1:0]  wbm_cti_i;
    logic [NUM_MASTERS*2-1:0]  wbm_bte_i;
    logic [31:0]               wbm_dat_o;
    logic [NUM_MASTERS-1:0]    wbm_ack_o;
    logic [NUM_MASTERS-1:0]    wbm_err_o;
    logic [NUM_MASTERS-1:0]    wbm_rty_o;

    logic [31:0]               wbs_adr_o;
    logic [31:0]               wbs_dat_o;
    logic [3:0]                wbs_sel_o;
    logic                      wbs_we_o;
    logic [2:0]                wbs_cti_o;
    logic [1:0]                wbs_bte_o;
    logic                      wbs_cyc_o;
    logic                      wbs_stb_o;
    logic [31:0]               wbs_dat_i;
    logic                      wbs_ack_i;
    logic                      wbs_err_i;
    logic                      wbs_rty_i;

    logic [NUM_MASTERS-1:0]    grant_o;

    // Arbiter view: slave to the masters, driver of the downstream bus.
    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i,
        input  wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o,
        output wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        output grant_o
    );

    // Environment view: the requesting masters plus the downstream slave.
    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i,
        output wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o,
        input  wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        input  grant_o
    );

endinterface

`default_nettype wire

// File: rtl/wb_io_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker: first request above i_last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N    = 2,
    parameter int IDXW = $clog2(N)
) (
    input  wire logic [N-1:0]    i_req,
    input  wire logic [IDXW-1:0] i_last,
    output logic      [N-1:0]    o_grant,
    output logic      [IDXW-1:0] o_idx,
    output logic                 o_valid
);

    localparam int CW = IDXW + 1;

    logic [CW-1:0] w_cand;

    // Scan last+1 .. last+N with wrap; the candidate has one spare bit for the sum.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int off = 1; off <= N; off++) begin
            w_cand = {1'b0, i_last} + CW'(off);
            if (w_cand >= CW'(N)) begin
                w_cand = w_cand - CW'(N);
            end
            if (!o_valid && i_req[w_cand[IDXW-1:0]]) begin
                o_valid                    = 1'b1;
                o_idx                      = w_cand[IDXW-1:0];
                o_grant[w_cand[IDXW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_io_arbiter.sv
// ============================================================================
// Module      : wb_io_arbiter
// Description : Round-robin Wishbone B4 classic arbiter for the wb_io port.
//               Optional watchdog enabled by WB_IO_ARBITER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_io_arbiter
    import wb_io_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  wire logic        wb_clk_i,
    input  wire logic        wb_rst_n_i,
    wb_io_arbiter_if.slave   bus
);

    localparam int                 IDXW        = $clog2(NUM_MASTERS);
    localparam logic [IDXW-1:0]    c_PTR_RESET = IDXW'(NUM_MASTERS - 1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("wb_io_arbiter: NUM_MASTERS must be 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_io_arbiter: TIMEOUT must be 1..65535");
    end

    wb_arb_state_e          r_state;
    wb_arb_state_e          w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [IDXW-1:0]        r_last;
    logic [IDXW-1:0]        w_last_nxt;

    logic [NUM_MASTERS-1:0] w_arb_grant;
    logic [IDXW-1:0]        w_arb_idx;
    logic                   w_arb_valid;

    logic [31:0]            w_adr;
    logic [31:0]            w_dat;
    logic [3:0]             w_sel;
    logic                   w_we;
    logic [2:0]             w_cti;
    logic [1:0]             w_bte;
    logic                   w_cyc_sel;
    logic                   w_stb_sel;
    logic                   w_in_busy;
    logic                   w_in_abort;
    logic                   w_wbs_stb;
    logic                   w_timeout;

    rr_arbiter #(
        .N    (NUM_MASTERS),
        .IDXW (IDXW)
    ) u_rr (
        .i_req   (bus.wbm_cyc_i),
        .i_last  (r_last),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // One-hot grant mux; an empty grant yields all-zero request fields.
    always_comb begin
        w_adr = '0;
        w_dat = '0;
        w_sel = '0;
        w_we  = 1'b0;
        w_cti = '0;
        w_bte = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_adr = bus.wbm_adr_i[i*32 +: 32];
                w_dat = bus.wbm_dat_i[i*32 +: 32];
                w_sel = bus.wbm_sel_i[i*4 +: 4];
                w_we  = bus.wbm_we_i[i];
                w_cti = bus.wbm_cti_i[i*3 +: 3];
                w_bte = bus.wbm_bte_i[i*2 +: 2];
            end
        end
    end

    assign w_cyc_sel  = |(r_grant & bus.wbm_cyc_i);
    assign w_stb_sel  = |(r_grant & bus.wbm_stb_i);
    assign w_in_busy  = (r_state == BUSY);
    assign w_in_abort = (r_state == ABORT);
    assign w_wbs_stb  = w_in_busy & w_cyc_sel & w_stb_sel;

`ifdef WB_IO_ARBITER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] r_wdog;
    logic           w_stall;

    assign w_stall   = w_wbs_stb & ~(bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i);
    // Fires on the stall cycle that would bring the count to TIMEOUT.
    assign w_timeout = w_stall & (r_wdog == WDW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_wdog <= '0;
        end else if (w_stall && !w_timeout) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= c_PTR_RESET;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_arb_grant;
                    w_last_nxt  = w_arb_idx;
                end
            end
            BUSY: begin
                if (!w_cyc_sel) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt = ABORT;
                end
            end
            ABORT: begin
                if (!w_cyc_sel) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign bus.wbs_adr_o = w_adr;
    assign bus.wbs_dat_o = w_dat;
    assign bus.wbs_sel_o = w_sel;
    assign bus.wbs_we_o  = w_we;
    assign bus.wbs_cti_o = w_cti;
    assign bus.wbs_bte_o = w_bte;
    assign bus.wbs_cyc_o = w_in_busy & w_cyc_sel;
    assign bus.wbs_stb_o = w_wbs_stb;

    // Slave responses only pass in BUSY, so anything arriving during ABORT is dropped.
    assign bus.wbm_dat_o = bus.wbs_dat_i;
    assign bus.wbm_ack_o = w_in_busy ? (r_grant & {NUM_MASTERS{bus.wbs_ack_i}}) : '0;
    assign bus.wbm_rty_o = w_in_busy ? (r_grant & {NUM_MASTERS{bus.wbs_rty_i}}) : '0;
    assign bus.wbm_err_o = w_in_abort ? r_grant
                         : (w_in_busy ? (r_grant & {NUM_MASTERS{bus.wbs_err_i}}) : '0);
    assign bus.grant_o   = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_wb_io_arbiter.sv
// ============================================================================
// Module      : tb_wb_io_arbiter
// Description : Directed self-checking bench for wb_io_arbiter (2 masters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_io_arbiter;
    import wb_io_pkg::*;

    localparam int NM = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wb_io_arbiter_if #(.NUM_MASTERS(NM)) bus();

    wb_io_arbiter #(
        .NUM_MASTERS (NM),
        .TIMEOUT     (8)
    ) u_dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        bus.wbm_cyc_i[m]          = cyc;
        bus.wbm_stb_i[m]          = stb;
        bus.wbm_we_i[m]           = we;
        bus.wbm_adr_i[m*32 +: 32] = adr;
        bus.wbm_dat_i[m*32 +: 32] = dat;
        bus.wbm_sel_i[m*4 +: 4]   = 4'hF;
        bus.wbm_cti_i[m*3 +: 3]   = cti;
        bus.wbm_bte_i[m*2 +: 2]   = BTE_LINEAR;
    endtask

    initial begin
        int cnt0;
        int cnt1;
        int exp_m;

        bus.wbm_adr_i = '0;
        bus.wbm_dat_i = '0;
        bus.wbm_sel_i = '0;
        bus.wbm_we_i  = '0;
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        bus.wbm_cti_i = '0;
        bus.wbm_bte_i = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_ack_i = 1'b0;
        bus.wbs_err_i = 1'b0;
        bus.wbs_rty_i = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_grant", 32'(bus.grant_o), 32'h0);
        check("rst_cyc",   32'(bus.wbs_cyc_o), 32'h0);
        check("rst_stb",   32'(bus.wbs_stb_o), 32'h0);
        check("rst_ack",   32'(bus.wbm_ack_o), 32'h0);
        check("rst_err",   32'(bus.wbm_err_o), 32'h0);
        check("rst_adr",   bus.wbs_adr_o, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single master write from master 1
        drive_m(1, 1'b1, 1'b1, 1'b1, 32'h1100, 32'hDEADBEEF, CTI_CLASSIC);
        #1;
        check("t1_cyc_lat0", 32'(bus.wbs_cyc_o), 32'h0);
        tick();
        check("t1_cyc",   32'(bus.wbs_cyc_o), 32'h1);
        check("t1_grant", 32'(bus.grant_o), 32'h2);
        check("t1_adr",   bus.wbs_adr_o, 32'h1100);
        check("t1_dat",   bus.wbs_dat_o, 32'hDEADBEEF);
        check("t1_we",    32'(bus.wbs_we_o), 32'h1);
        bus.wbs_ack_i = 1'b1;
        #1;
        check("t1_ack", 32'(bus.wbm_ack_o), 32'h2);
        tick();
        bus.wbs_ack_i = 1'b0;
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        #1;
        check("t1_cyc_drop", 32'(bus.wbs_cyc_o), 32'h0);
        tick();
        check("t1_grant_clr", 32'(bus.grant_o), 32'h0);

        // Contention right after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, CTI_CLASSIC);
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, CTI_CLASSIC);
        tick();
        check("t2_grant0", 32'(bus.grant_o), 32'h1);
        check("t2_adr0",   bus.wbs_adr_o, 32'h10);
        bus.wbs_ack_i = 1'b1;
        #1;
        check("t2_ack0", 32'(bus.wbm_ack_o), 32'h1);
        tick();
        bus.wbs_ack_i = 1'b0;
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        tick();
        check("t2_dead", 32'(bus.grant_o), 32'h0);
        tick();
        check("t2_grant1", 32'(bus.grant_o), 32'h2);
        check("t2_adr1",   bus.wbs_adr_o, 32'h20);
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        tick();
        tick();

        // Fairness: 4 reads per master, strict alternation expected
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            if (cnt0 < 4) drive_m(0, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, CTI_CLASSIC);
            if (cnt1 < 4) drive_m(1, 1'b1, 1'b1, 1'b0, 32'h2010, 32'h0, CTI_CLASSIC);
            for (int w = 0; w < 6 && bus.grant_o == '0; w++) tick();
            exp_m = i % 2;
            check("fair_grant", 32'(bus.grant_o), 32'(1) << exp_m);
            bus.wbs_dat_i = 32'hA000 + 32'(i);
            bus.wbs_ack_i = 1'b1;
            #1;
            check("fair_rdat", bus.wbm_dat_o, 32'hA000 + 32'(i));
            check("fair_ack",  32'(bus.wbm_ack_o), 32'(1) << exp_m);
            tick();
            bus.wbs_ack_i = 1'b0;
            drive_m(exp_m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
            if (exp_m == 0) cnt0++; else cnt1++;
            tick();
        end

        // Burst hold: master 0 4-beat incrementing burst, master 1 waiting
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h4000, 32'h0, CTI_INCR);
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h5000, 32'h0, CTI_CLASSIC);
        tick();
        check("burst_grant0", 32'(bus.grant_o), 32'h1);
        for (int b = 0; b < 4; b++) begin
            bus.wbm_cti_i[2:0] = (b == 3) ? CTI_EOB : CTI_INCR;
            bus.wbs_ack_i = 1'b1;
            #1;
            check("burst_cti",  32'(bus.wbs_cti_o), (b == 3) ? 32'h7 : 32'h2);
            check("burst_hold", 32'(bus.grant_o), 32'h1);
            tick();
        end
        bus.wbs_ack_i = 1'b0;
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        tick();
        check("burst_dead", 32'(bus.grant_o), 32'h0);
        tick();
        check("burst_grant1", 32'(bus.grant_o), 32'h2);
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        tick();
        tick();

        // Watchdog: master 0 strobes, slave never responds
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h3000, 32'h0, CTI_CLASSIC);
        tick();
`ifdef WB_IO_ARBITER_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            check("wd_stb_wait", 32'(bus.wbs_stb_o), 32'h1);
            check("wd_err_wait", 32'(bus.wbm_err_o), 32'h0);
            tick();
        end
        bus.wbs_ack_i = 1'b1;
        #1;
        check("wd_abort_stb", 32'(bus.wbs_stb_o), 32'h0);
        check("wd_abort_cyc", 32'(bus.wbs_cyc_o), 32'h0);
        check("wd_abort_err", 32'(bus.wbm_err_o), 32'h1);
        check("wd_abort_ack", 32'(bus.wbm_ack_o), 32'h0);
        tick();
        bus.wbs_ack_i = 1'b0;
        #1;
        check("wd_resume_stb", 32'(bus.wbs_stb_o), 32'h1);
        check("wd_resume_err", 32'(bus.wbm_err_o), 32'h0);
`else
        for (int k = 0; k < 12; k++) begin
            check("wd_off_stb", 32'(bus.wbs_stb_o), 32'h1);
            check("wd_off_err", 32'(bus.wbm_err_o), 32'h0);
            tick();
        end
`endif
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        tick();
        tick();

        // Async reset during a granted read of master 0
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h6000, 32'h0, CTI_CLASSIC);
        tick();
        check("ar_grant_pre", 32'(bus.grant_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_cyc",   32'(bus.wbs_cyc_o), 32'h0);
        check("ar_grant", 32'(bus.grant_o), 32'h0);
        tick();
        rst_n = 1'b1;
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h7000, 32'h0, CTI_CLASSIC);
        tick();
        check("ar_first_m0", 32'(bus.grant_o), 32'h1);
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CTI_CLASSIC);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_io_arbiter.md
# wb_io_arbiter

Round-robin Wishbone B4 classic arbiter that lets NUM_MASTERS bus masters share the single `wb_io` port of the SoC I/O interconnect. Typical masters are the SweRV core's I/O bridge and a DMA or VGA fetch engine. The block sits between those masters and the I/O address decoder/mux. It grants the bus for the whole duration of a master's `cyc`, forwards the granted master's signals, and routes responses back to that master only. An optional watchdog ends stuck transfers with an error response.

## Interface
- NUM_MASTERS, 2, number of requesting masters (2..8)
- TIMEOUT, 255, cycles a strobe may wait for ack/err/rty before the watchdog fires (1..65535)
- wb_clk_i  in  1  bus clock
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low
- wbm_adr_i  in  NUM_MASTERS*32  master addresses, master 0 in LSBs
- wbm_dat_i  in  NUM_MASTERS*32  master write data
- wbm_sel_i  in  NUM_MASTERS*4  byte selects
- wbm_we_i  in  NUM_MASTERS  write enables
- wbm_cyc_i  in  NUM_MASTERS  cycle requests
- wbm_stb_i  in  NUM_MASTERS  strobes
- wbm_cti_i  in  NUM_MASTERS*3  cycle type
- wbm_bte_i  in  NUM_MASTERS*2  burst type
- wbm_dat_o  out  32  read data, broadcast to all masters
- wbm_ack_o  out  NUM_MASTERS  ack, routed to granted master only
- wbm_err_o  out  NUM_MASTERS  err, routed to granted master, or watchdog error
- wbm_rty_o  out  NUM_MASTERS  rty, routed to granted master only
- wbs_adr_o / wbs_dat_o / wbs_sel_o / wbs_we_o / wbs_cti_o / wbs_bte_o  out  32/32/4/1/3/2  granted master's request
- wbs_cyc_o  out  1  granted cyc
- wbs_stb_o  out  1  granted stb
- wbs_dat_i / wbs_ack_i / wbs_err_i / wbs_rty_i  in  32/1/1/1  slave response
- grant_o  out  NUM_MASTERS  one-hot current grant, all zero when idle

## Operation
- States: IDLE, BUSY, ABORT. Reset state is IDLE, with last-grant pointer = NUM_MASTERS-1, so master 0 wins first.
- IDLE: if any `wbm_cyc_i` is high, select the first requester scanning upward from last_grant+1 with wrap-around. Register the one-hot grant, update the pointer, go to BUSY. With no requests, stay in IDLE.
- BUSY: forward the granted master's request to `wbs_*_o`. Route `wbs_ack_i`, `wbs_err_i` and `wbs_rty_i` to the granted bit only; all other bits are 0. `wbm_dat_o` = `wbs_dat_i` unregistered.
- BUSY→IDLE when the granted `wbm_cyc_i` is low. Grant clears on the same edge. Bursts and RMW sequences that keep cyc high are never broken.
- Non-granted masters see ack/err/rty = 0 and wait.
- ABORT (watchdog only): see Configuration.
- Reset asserted mid-transfer: grant clears immediately (async), all outputs go to their reset values, state is IDLE.

## Timing
- Reset values: `wbs_cyc_o`=0, `wbs_stb_o`=0, `grant_o`=0, `wbm_ack_o`/`wbm_err_o`/`wbm_rty_o`=0. Other `wbs_*_o` outputs are 0 while idle.
- Grant latency: cyc rises at edge n → `wbs_cyc_o` rises after edge n+1.
- Response path is combinational: slave ack in cycle k → master ack in cycle k.
- Release: one dead cycle (IDLE) between consecutive grants. Back-to-back requests from two masters alternate.
- Simultaneous requests: only the round-robin pointer decides the winner. Starvation bound is (NUM_MASTERS-1) transactions.

## Configuration
- `WB_IO_ARBITER_TIMEOUT_EN` defined: a counter of width $clog2(TIMEOUT+1) increments each BUSY cycle with `wbs_stb_o`=1 and no ack/err/rty.
  - It clears on any response or when stb is low.
  - When it reaches TIMEOUT: enter ABORT for exactly one cycle. In ABORT, `wbs_cyc_o`=`wbs_stb_o`=0 and `wbm_err_o` is pulsed to the granted master.
  - ABORT then goes to BUSY if the master's cyc is still high, otherwise to IDLE.
  - A slave response arriving in the ABORT cycle is dropped.
- Macro undefined: no counter, no ABORT state. A stuck slave holds the bus indefinitely.

## Structure
- Shared package `wb_io_pkg`: `wb_arb_state_e` enum (IDLE, BUSY, ABORT) and Wishbone CTI/BTE localparams (CTI_CLASSIC=3'b000, CTI_EOB=3'b111).
- Sub-module `rr_arbiter` (request vector, pointer → one-hot grant, combinational). It is reusable for other shared-resource arbiters.

## Test plan
- Single master: master 1 writes 0xDEADBEEF to 0x1100 → `wbs_cyc_o` rises one cycle after `wbm_cyc_i[1]`, `grant_o`=2'b10, ack seen only on `wbm_ack_o[1]`.
- Contention: both cyc rise in the same cycle after reset → master 0 granted first; master 1 is granted after master 0 drops cyc plus one idle cycle.
- Fairness: both masters issue 4 back-to-back reads each → grants strictly alternate 0,1,0,1,…
- Burst hold: master 0 runs a 4-beat burst (cti 010, last 111) while master 1 requests → master 1 is not granted until master 0's cyc drops.
- Watchdog (macro on, TIMEOUT=8): slave never acks → err on the granted master exactly 8 cycles after stb, slave stb low for one cycle. With the macro off, stb stays high.
- Async reset: assert `wb_rst_n_i` during a granted read → `wbs_cyc_o` and `grant_o` go to 0 without a clock edge; after release, master 0 has first priority again.
